// File: rtl/i2s_rx_frame_ctrl_pkg.sv
// Shared definitions for the I2S receive frame controller: FSM state codes and a
// width helper used by the controller and its sample FIFO.
package i2s_rx_frame_ctrl_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_SYNC   = 2'd1;
   localparam state_t ST_CHECK  = 2'd2;
   localparam state_t ST_LOCKED = 2'd3;

   // Bits needed to index 'value' entries (ceil(log2(value))), never less than 1.
   function automatic int clogb2(input int value);
      int bits;
      bits = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         bits++;
      end
      return (bits < 1) ? 1 : bits;
   endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous show-ahead FIFO for received {L,R} words. Flush empties it in one cycle;
// a push while full is accepted only when a pop happens in the same cycle.
module i2s_sample_fifo
   import i2s_rx_frame_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int AW = clogb2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CNT_FULL);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   // Head reads as zero when empty so stale entries never leak out after a flush.
   assign data_o  = empty_o ? '0 : mem_q[rd_q];

   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            wr_q <= wr_q + AW'(1);
         end
         if (do_pop) begin
            rd_q <= rd_q + AW'(1);
         end
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) begin
         mem_q[wr_q] <= data_i;
      end
   end

endmodule

// File: rtl/i2s_rx_frame_ctrl.sv
// I2S receive supervisor: holds the receiver in reset until enabled, qualifies LRCLK/BCLK
// framing, declares lock after LOCK_FRAMES clean frames and only then forwards words.
module i2s_rx_frame_ctrl
   import i2s_rx_frame_ctrl_pkg::*;
#(
   parameter int DATA_BITS   = 32,
   parameter int BCLK_HALF   = 32,
   parameter int LOCK_FRAMES = 4,
   parameter int TIMEOUT     = 1023,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                 xclk,
   input  logic                 xrst_n,
   input  logic                 enable,
   input  logic                 xBrise,
   input  logic                 xLRrise,
   input  logic                 xLRfall,
   input  logic [DATA_BITS-1:0] xData,
   input  logic                 xData_rdy,
   output logic                 rcv_rst,
   output logic                 locked,
   output logic [DATA_BITS-1:0] smp_data,
   output logic                 smp_valid,
   input  logic                 smp_ready,
   output logic                 overflow,
   output logic [7:0]           lost_cnt
);

   localparam int HCNT_W = clogb2(BCLK_HALF + 2);
   localparam int TCNT_W = clogb2(TIMEOUT + 1);
   localparam int GCNT_W = 4;
   localparam logic [HCNT_W-1:0] HCNT_HALF = HCNT_W'(BCLK_HALF);
   localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(BCLK_HALF + 1);
   localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TIMEOUT);
   localparam logic [TCNT_W-1:0] TCNT_PRE  = TCNT_W'(TIMEOUT - 1);
   localparam logic [GCNT_W-1:0] GCNT_LOCK = GCNT_W'(LOCK_FRAMES);

   state_t            state_q, state_d;
   logic [HCNT_W-1:0] hcnt_q, hcnt_d;
   logic              lgood_q, lgood_d;
   logic [TCNT_W-1:0] tcnt_q, tcnt_d;
   logic [GCNT_W-1:0] good_q, good_d;
   logic [7:0]        lost_q, lost_d;
   logic              locked_q, rcv_rst_q, overflow_q;
   logic              lr_edge, half_good, frame_good, timeout_hit, lose_lock;
   logic              flush, push_req, fifo_full, fifo_empty;

   assign lr_edge    = xLRrise | xLRfall;
   assign half_good  = (hcnt_q == HCNT_HALF);
   assign frame_good = lgood_q & half_good;

   // A BCLK strobe coinciding with an LR edge belongs to the half that edge opens.
   always_comb begin
      hcnt_d = hcnt_q;
      if (lr_edge) begin
         hcnt_d = HCNT_W'(xBrise);
      end else if (xBrise && (hcnt_q != HCNT_MAX)) begin
         hcnt_d = hcnt_q + HCNT_W'(1);
      end
   end

   assign lgood_d = xLRrise ? half_good : lgood_q;

   always_comb begin
      state_d     = state_q;
      good_d      = good_q;
      lose_lock   = 1'b0;
      tcnt_d      = tcnt_q;
      timeout_hit = (state_q != ST_IDLE) && !lr_edge && (tcnt_q == TCNT_PRE);
      if ((state_q == ST_IDLE) || lr_edge) begin
         tcnt_d = '0;
      end else if (tcnt_q != TCNT_MAX) begin
         tcnt_d = tcnt_q + TCNT_W'(1);
      end
      case (state_q)
         ST_IDLE: begin
            good_d = '0;
            if (enable) state_d = ST_SYNC;
         end
         ST_SYNC: begin
            if (xLRfall) begin
               state_d = ST_CHECK;
               good_d  = '0;
            end
         end
         ST_CHECK: begin
            if (xLRfall) begin
               if (frame_good) begin
                  good_d = good_q + GCNT_W'(1);
                  if ((good_q + GCNT_W'(1)) == GCNT_LOCK) state_d = ST_LOCKED;
               end else begin
                  good_d = '0;
               end
            end else if (timeout_hit) begin
               state_d = ST_SYNC;
            end
         end
         default: begin
            if ((xLRfall && !frame_good) || timeout_hit) begin
               state_d   = ST_SYNC;
               lose_lock = 1'b1;
            end
         end
      endcase
      // Disable overrides everything, including a lock loss in the same cycle.
      if (!enable) begin
         state_d   = ST_IDLE;
         good_d    = '0;
         tcnt_d    = '0;
         lose_lock = 1'b0;
      end
   end

   assign lost_d   = (lose_lock && (lost_q != 8'hFF)) ? lost_q + 8'd1 : lost_q;
   assign flush    = (state_d == ST_IDLE);
   assign push_req = (state_q == ST_LOCKED) && xData_rdy && lgood_q &&
                     (hcnt_q <= HCNT_HALF) && !flush;

   always_ff @(posedge xclk) begin
      if (!xrst_n) begin
         state_q    <= ST_IDLE;
         hcnt_q     <= '0;
         lgood_q    <= 1'b0;
         tcnt_q     <= '0;
         good_q     <= '0;
         lost_q     <= '0;
         locked_q   <= 1'b0;
         rcv_rst_q  <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hcnt_q     <= hcnt_d;
         lgood_q    <= lgood_d;
         tcnt_q     <= tcnt_d;
         good_q     <= good_d;
         lost_q     <= lost_d;
         locked_q   <= (state_d == ST_LOCKED);
         rcv_rst_q  <= (state_d == ST_IDLE);
         overflow_q <= push_req && fifo_full && !smp_ready;
      end
   end

   i2s_sample_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (xclk),
      .rst_ni  (xrst_n),
      .flush_i (flush),
      .push_i  (push_req),
      .data_i  (xData),
      .pop_i   (smp_ready),
      .data_o  (smp_data),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   assign smp_valid = ~fifo_empty;
   assign locked    = locked_q;
   assign rcv_rst   = rcv_rst_q;
   assign overflow  = overflow_q;
   assign lost_cnt  = lost_q;

endmodule
